// File: rtl/serial_lane_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_lane_pkg: FSM state type and width helpers for serial_lane_scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
package serial_lane_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

  // Counter width that stays legal (>=1) even when the count is 1.
  function automatic int cnt_w(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_lane_scheduler_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter: combinational round-robin pick, first set req at or above rr_ptr
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter
  import serial_lane_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]        gnt_onehot,
  output logic [clog2(NUM_REQ)-1:0] gnt_id,
  output logic                      any
);

  localparam int IDW = clog2(NUM_REQ);

  always_comb begin
    int idx;
    idx        = 0;
    gnt_onehot = '0;
    gnt_id     = '0;
    any        = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_id          = IDW'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_lane_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serial_lane_scheduler: round-robin shared serial lane, LSB-first framing;
// define SERIAL_LANE_PARITY_EN to append an even-parity bit.  Rev 1.0
// ----------------------------------------------------------------------------
module serial_lane_scheduler
  import serial_lane_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WORD_W     = 8,
  parameter int BIT_CYCLES = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*WORD_W-1:0]   data,
  output logic [NUM_REQ-1:0]          ack,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        ser_out,
  output logic                        ser_valid,
  output logic [$clog2(WORD_W+1)-1:0] bit_idx
);

  localparam int IDW = clog2(NUM_REQ);
  localparam int BIW = clog2(WORD_W + 1);
  localparam int BCW = cnt_w(BIT_CYCLES);
  localparam int GCW = cnt_w(GAP_CYCLES);
`ifdef SERIAL_LANE_PARITY_EN
  localparam int LAST_IDX = WORD_W;
`else
  localparam int LAST_IDX = WORD_W - 1;
`endif
  localparam logic [BCW-1:0] BC_LAST  = BCW'(BIT_CYCLES - 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYCLES - 1);
  localparam logic [BIW-1:0] BI_LAST  = BIW'(LAST_IDX);

  state_t              state_q,     state_d;
  logic [IDW-1:0]      rr_ptr_q,    rr_ptr_d;
  logic [BCW-1:0]      bit_cnt_q,   bit_cnt_d;
  logic [GCW-1:0]      gap_cnt_q,   gap_cnt_d;
  logic [BIW-1:0]      bit_idx_q,   bit_idx_d;
  logic [WORD_W-1:0]   shreg_q,     shreg_d;
  logic                ser_out_q,   ser_out_d;
  logic                ser_valid_q, ser_valid_d;
  logic                busy_q,      busy_d;
  logic [IDW-1:0]      grant_id_q,  grant_id_d;
  logic [NUM_REQ-1:0]  ack_q,       ack_d;
  logic [NUM_REQ-1:0]  eligible_q,  eligible_d;
`ifdef SERIAL_LANE_PARITY_EN
  logic                parity_q,    parity_d;
`endif

  logic [NUM_REQ-1:0]  arb_req;
  logic [NUM_REQ-1:0]  arb_onehot;
  logic [IDW-1:0]      arb_id;
  logic                arb_any;
  logic [WORD_W-1:0]   win_word;

  // A requester is eligible only once its req has been seen low after reset,
  // so a word whose ack was lost to a reset is not re-granted while still held.
  assign arb_req  = req & eligible_q;
  assign win_word = data[int'(arb_id)*WORD_W +: WORD_W];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req        (arb_req),
    .rr_ptr     (rr_ptr_q),
    .gnt_onehot (arb_onehot),
    .gnt_id     (arb_id),
    .any        (arb_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      grant_id_q  <= '0;
      ack_q       <= '0;
      eligible_q  <= '0;
`ifdef SERIAL_LANE_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      busy_q      <= busy_d;
      grant_id_q  <= grant_id_d;
      ack_q       <= ack_d;
      eligible_q  <= eligible_d;
`ifdef SERIAL_LANE_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = ser_valid_q;
    busy_d      = busy_q;
    grant_id_d  = grant_id_q;
    ack_d       = '0;
    eligible_d  = eligible_q | ~req;
`ifdef SERIAL_LANE_PARITY_EN
    parity_d    = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d     = SHIFT;
          ack_d       = arb_onehot;
          grant_id_d  = arb_id;
          rr_ptr_d    = (arb_id == IDW'(NUM_REQ - 1)) ? '0 : arb_id + IDW'(1);
          shreg_d     = win_word;
          ser_out_d   = win_word[0];
          ser_valid_d = 1'b1;
          busy_d      = 1'b1;
          bit_idx_d   = '0;
          bit_cnt_d   = '0;
`ifdef SERIAL_LANE_PARITY_EN
          parity_d    = ^win_word;
`endif
        end
      end

      SHIFT: begin
        if (bit_cnt_q == BC_LAST) begin
          bit_cnt_d = '0;
          if (bit_idx_q == BI_LAST) begin
            state_d     = GAP;
            ser_out_d   = 1'b0;
            ser_valid_d = 1'b0;
            bit_idx_d   = '0;
            gap_cnt_d   = '0;
          end else begin
            bit_idx_d = bit_idx_q + BIW'(1);
            shreg_d   = shreg_q >> 1;
`ifdef SERIAL_LANE_PARITY_EN
            ser_out_d = (bit_idx_q == BIW'(WORD_W - 1)) ? parity_q : shreg_q[1];
`else
            ser_out_d = shreg_q[1];
`endif
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GCW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ack       = ack_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign bit_idx   = bit_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_lane_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_serial_lane_scheduler: vector table, corner sequences and random traffic
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_serial_lane_scheduler;

  localparam int NR = 4;
  localparam int WW = 8;
  localparam int BC = 4;
  localparam int GC = 2;
`ifdef SERIAL_LANE_PARITY_EN
  localparam int NB = WW + 1;
`else
  localparam int NB = WW;
`endif
  localparam int EXP_BUSY = NB * BC + GC;
  localparam int SPACING  = NB * BC + GC + 1;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic [3:0]  req  = '0;
  logic [31:0] data = '0;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic        ser_out;
  logic        ser_valid;
  logic [3:0]  bit_idx;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  serial_lane_scheduler #(
    .NUM_REQ    (NR),
    .WORD_W     (WW),
    .BIT_CYCLES (BC),
    .GAP_CYCLES (GC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .ack       (ack),
    .grant_id  (grant_id),
    .busy      (busy),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .bit_idx   (bit_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  exp_ack;
    logic [1:0]  exp_gid;
    logic [7:0]  exp_word;
    logic        exp_par;
  } vec_t;

  vec_t vecs [5];

  task automatic do_frame(input vec_t v);
    logic [8:0] exp_bits;
    int         busy_cnt;
    exp_bits = {v.exp_par, v.exp_word};
    busy_cnt = 0;
    @(negedge clk);
    req  = v.req;
    data = v.data;
    @(negedge clk);
    check("frame_ack", ack, v.exp_ack);
    check("frame_gid", grant_id, v.exp_gid);
    req = '0;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < BC; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        check("frame_bit", {ser_valid, ser_out, bit_idx}, {1'b1, exp_bits[b], 4'(b)});
        if (busy) busy_cnt++;
      end
    end
    @(negedge clk);
    check("frame_gap_out", {ser_valid, ser_out, bit_idx}, 32'd0);
    for (int t = 0; t < 100 && busy; t++) begin
      busy_cnt++;
      @(negedge clk);
    end
    check("frame_busy_len", busy_cnt, EXP_BUSY);
  endtask

  typedef struct packed {
    logic       so;
    logic       sv;
    logic       bsy;
    logic [3:0] bi;
  } rec_t;

  initial begin
    logic [3:0] exp_rr [5];
    logic [7:0] words [4];
    rec_t       q [$];
    rec_t       cur;
    rec_t       r;
    logic [3:0] ack_exp;
    logic [1:0] gexp;
    int         ptr;
    int         got;
    int         last_t;
    int         acks;
    int         w;
    logic       par;

    vecs[0] = '{4'b0001, 32'h000000A5, 4'b0001, 2'd0, 8'hA5, 1'b0};
    vecs[1] = '{4'b0100, 32'h003C0000, 4'b0100, 2'd2, 8'h3C, 1'b0};
    vecs[2] = '{4'b0011, 32'h0000F00F, 4'b0001, 2'd0, 8'h0F, 1'b0};
    vecs[3] = '{4'b1010, 32'h5A000700, 4'b0010, 2'd1, 8'h07, 1'b1};
    vecs[4] = '{4'b1001, 32'h030000E1, 4'b1000, 2'd3, 8'h03, 1'b0};
    exp_rr  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // reset state
    @(negedge clk);
    check("reset_outputs", {ack, grant_id, busy, ser_out, ser_valid, bit_idx}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {ack, busy, ser_valid}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      do_frame(vecs[i]);
    end

    // round-robin under continuous load
    req  = 4'hF;
    data = 32'h44332211;
    got  = 0;
    last_t = 0;
    for (int t = 0; t < 300 && got < 5; t++) begin
      @(negedge clk);
      if (ack != 4'b0000) begin
        check("rr_ack", ack, exp_rr[got]);
        if (got > 0) check("rr_spacing", cyc - last_t, SPACING);
        last_t = cyc;
        got++;
      end
    end
    req = '0;
    check("rr_count", got, 5);
    for (int t = 0; t < 100 && busy; t++) @(negedge clk);

    // late request raised in SHIFT, withdrawn in GAP
    req  = 4'b0010;
    data = 32'h0099C300;
    @(negedge clk);
    check("late_ack1", ack, 4'b0010);
    req  = '0;
    acks = 0;
    repeat (5) @(negedge clk);
    req[2] = 1'b1;
    for (int t = 0; t < 100 && ser_valid; t++) begin
      @(negedge clk);
      if (ack[2]) acks++;
    end
    check("late_in_gap", {busy, ser_valid}, 32'h2);
    req[2] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack[2]) acks++;
    end
    check("late_no_ack2", acks, 0);
    check("late_idle", {busy, ser_valid}, 32'd0);

    // reset mid-frame
    req  = 4'b0010;
    data = 32'h0000FF00;
    @(negedge clk);
    check("rst_ack", {ack, grant_id}, {4'b0010, 2'd1});
    for (int t = 0; t < 50 && bit_idx != 4'd3; t++) @(negedge clk);
    check("rst_bitidx_reached", {bit_idx, ser_out}, {4'd3, 1'b1});
    #2 rst = 1'b1;
    #1;
    check("rst_async", {ack, grant_id, busy, ser_out, ser_valid, bit_idx}, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    acks = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (ack != 4'b0000 || busy) acks++;
    end
    check("rst_no_reack", acks, 0);
    req = '0;
    @(negedge clk);
    @(negedge clk);

    // randomized traffic against a frame-level model
    ptr     = 0;
    gexp    = 2'd0;
    ack_exp = '0;
    for (int i = 0; i < 4; i++) words[i] = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req[i] && $urandom_range(7) == 0) begin
          words[i]       = 8'($urandom);
          data[i*8 +: 8] = words[i];
          req[i]         = 1'b1;
        end else if (req[i] && $urandom_range(63) == 0) begin
          req[i] = 1'b0;
        end
      end
      ack_exp = '0;
      if (q.size() == 0 && req != 4'b0000) begin
        w = -1;
        for (int off = 0; off < NR; off++) begin
          if (w < 0 && req[(ptr + off) % NR]) w = (ptr + off) % NR;
        end
        par = ($countones(words[w]) % 2) == 1;
        for (int b = 0; b < NB; b++) begin
          for (int c = 0; c < BC; c++) begin
            r.so  = (b < WW) ? words[w][b] : par;
            r.sv  = 1'b1;
            r.bsy = 1'b1;
            r.bi  = 4'(b);
            q.push_back(r);
          end
        end
        for (int g = 0; g < GC; g++) q.push_back(rec_t'{1'b0, 1'b0, 1'b1, 4'd0});
        q.push_back(rec_t'{1'b0, 1'b0, 1'b0, 4'd0});
        ack_exp[w] = 1'b1;
        gexp       = 2'(w);
        ptr        = (w + 1) % NR;
      end
      if (q.size() > 0) cur = q.pop_front();
      else              cur = '0;
      @(negedge clk);
      check("random", {ack, grant_id, busy, ser_out, ser_valid, bit_idx},
            {ack_exp, gexp, cur.bsy, cur.so, cur.sv, cur.bi});
      req = req & ~ack_exp;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
